// File: rtl/imm_extend_pipe.sv
// Parametrised MIPS immediate extender (sign / zero / branch-offset / upper) feeding a result FIFO.
// Optional push statistics counters are enabled with the IMM_EXTEND_STATS_EN macro.

// Generic single-clock FIFO with an explicit occupancy counter and synchronous clear.
// Latency: a word pushed at edge k is visible at the head after edge k.
// Backpressure: push_rdy is low only when full and depends on registered state only.
module imm_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push_vld,
  output logic                     push_rdy,
  input  logic [W-1:0]             push_dat,
  output logic                     pop_vld,
  input  logic                     pop_rdy,
  output logic [W-1:0]             pop_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;

  assign push_rdy = (cnt != CW'(DEPTH));
  assign pop_vld  = (cnt != '0);
  assign pop_dat  = mem[rd_ptr];
  assign count    = cnt;

  // A flush wins over any handshake in the same cycle.
  assign push = push_vld & push_rdy & ~flush;
  assign pop  = pop_vld & pop_rdy & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is deliberately left out of reset; validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

endmodule

// Extends an IN_W-bit field to OUT_W bits in one of four modes and queues the result.
// Latency: 1 cycle from accepted input to result at the FIFO head.
// Backpressure: in_ready deasserts only when the FIFO is full; no combinational path from out_ready.
module imm_extend_pipe #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_imm,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count
`ifdef IMM_EXTEND_STATS_EN
  ,
  output logic [15:0]              stat_total,
  output logic [15:0]              stat_neg
`endif
);

  localparam int PAD = OUT_W - IN_W;

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_BRANCH = 2'b10,
    MODE_UPPER  = 2'b11
  } mode_e;

  generate
    if (OUT_W < IN_W + 2) begin : g_bad_width
      $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("imm_extend_pipe: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] ext_dat;

  assign sext = {{PAD{in_imm[IN_W-1]}}, in_imm};
  assign zext = {{PAD{1'b0}}, in_imm};

  always_comb begin
    ext_dat = sext;
    case (mode_e'(in_mode))
      MODE_SIGN:   ext_dat = sext;
      MODE_ZERO:   ext_dat = zext;
      MODE_BRANCH: ext_dat = {sext[OUT_W-3:0], 2'b00};
      MODE_UPPER:  ext_dat = {in_imm, {PAD{1'b0}}};
      default:     ext_dat = sext;
    endcase
  end

  imm_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (ext_dat),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (out_data),
    .count    (count)
  );

`ifdef IMM_EXTEND_STATS_EN
  logic stat_push;

  assign stat_push = in_valid & in_ready & ~flush;

  // Counters wrap freely; software is expected to sample differences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_total <= '0;
      stat_neg   <= '0;
    end else if (flush) begin
      stat_total <= '0;
      stat_neg   <= '0;
    end else if (stat_push) begin
      stat_total <= stat_total + 16'd1;
      if (ext_dat[OUT_W-1]) stat_neg <= stat_neg + 16'd1;
    end
  end
`endif

endmodule
